seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
//   Time-multiplexed 4-digit seven-segment driver for the memory game display.
//   Sits directly downstream of the clock divider: consumes its clk_fast (scan
//   rate) and clk_1 (blink rate) square waves as synchronised level inputs.
//   Everything runs on the single system clock.
//   Adds frame-coherent value latching, per-digit blank/blink, and an anti-ghost
//   guard interval between digits.
// PARAMETERS
//   GUARD_CYCLES  16  clk cycles with all anodes off after each digit advance (0 = no guard)
// PORTS
//   clk        in   1   system clock (100 MHz)
//   rst        in   1   asynchronous, active-high reset
//   clk_fast   in   1   scan-rate square wave from divider (~1 kHz), asynchronous to clk
//   clk_1      in   1   blink-rate square wave from divider, asynchronous to clk
//   value      in   16  four hex nibbles; digit i = value[4i+3:4i]
//   dp_in      in   4   decimal point request per digit, 1 = lit
//   blank      in   4   1 = digit i dark
//   blink      in   4   1 = digit i dark while clk_1 (synced) is high
//   an         out  4   anodes, active-low, one-hot-low or all-1
//   seg        out  7   {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point, active-low
//   digit_idx  out  2   index of digit currently selected
// BEHAVIOUR
//   Reset (async, immediate): an=4'hF, seg=7'h7F, dp=1, digit_idx=3, state=IDLE,
//     all sync flops, shadow regs and guard counter = 0.
//   Sync: clk_fast -> 3 flops (f1,f2,f3); scan_tick = f2 & ~f3, one clk wide,
//     3 clk edges after clk_fast rises. clk_1 -> 2 flops -> blink_s.
//   FSM states IDLE, GUARD, DRIVE:
//     IDLE: outputs dark; on scan_tick -> advance (below).
//     Advance (scan_tick in any state): digit_idx <= digit_idx+1 mod 4 (3 wraps to 0);
//       an <= 4'hF; if GUARD_CYCLES>0: state <= GUARD, cnt <= GUARD_CYCLES-1;
//       else state <= DRIVE.
//     GUARD: an=4'hF; cnt decrements each cycle; cycle with cnt==0 -> DRIVE next.
//       Guard lasts exactly GUARD_CYCLES cycles.
//     DRIVE: holds until next scan_tick.
//   Tick during GUARD restarts guard for the next digit (tick wins, no DRIVE).
//   Frame latch: on the advance where digit_idx goes 3->0 (incl. first tick after
//     reset), value/dp_in/blank/blink copied to shadow regs; mid-frame input
//     changes never appear until next frame.
//   DRIVE outputs (registered, valid from first DRIVE cycle):
//     dark_i = blank_sh[i] | (blink_sh[i] & blink_s); blink_s is live, not latched.
//     an = dark_i ? 4'hF : ~(4'b0001 << i); seg = dark_i ? 7'h7F : decode(nibble_sh[i]);
//     dp = dark_i ? 1 : ~dp_sh[i].
//   Decode (active-low {g..a}): 0=1000000 1=1111001 2=0100100 3=0110000
//     4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//     A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//   In IDLE/GUARD: seg=7'h7F, dp=1.
//   Never more than one anode low; an never changes directly from one
//     low digit to another while GUARD_CYCLES>0.
// TESTING
//   Reset, clk_fast rising pulse -> idx 0, an=4'hF for 16 cycles, then an=4'b1110,
//     seg=decode(value[3:0]).
//   value=16'h8A01, four ticks -> digits show 1 (1111001), 0 (1000000),
//     A (0001000), 8 (0000000); an 1110,1101,1011,0111, then wrap to 1110.
//   Change value mid-frame (after idx 1) -> digits 2,3 keep old nibbles;
//     new value appears from idx 0.
//   blank=4'b0100 -> an=4'hF during idx 2; blink=4'b0001 with clk_1 high ->
//     digit 0 dark, clk_1 low -> lit.
//   Two ticks 5 cycles apart (GUARD_CYCLES=16) -> idx advances twice, an stays 4'hF
//     throughout, DRIVE reached 16 cycles after second tick.
//   Assert rst during DRIVE -> an=4'hF, seg=7'h7F, idx=3 same edge (async);
//     next tick resumes at idx 0.

Source files
------------

// File: rtl/seven_seg_if.sv
// Signal bundle between the memory-game controller side and the seven-segment scanner.
// The scan and blink waves are free-running levels, and the digit inputs are sampled levels, so no transfer handshake is needed.
interface seven_seg_if;
    logic        clk_fast;
    logic        clk_1;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic [1:0]  state_dbg;

    modport master (
        output clk_fast, clk_1, value, dp_in, blank, blink,
        input  an, seg, dp, digit_idx, state_dbg
    );

    modport slave (
        input  clk_fast, clk_1, value, dp_in, blank, blink,
        output an, seg, dp, digit_idx, state_dbg
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit seven-segment scanner with frame latching, blank/blink
// and an all-anodes-off guard interval after every digit advance.
module seven_seg_scan #(
    parameter int GUARD_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    seven_seg_if.slave   bus
);

    localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  fsync_q, fsync_d;
    logic [1:0]  bsync_q, bsync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] value_sh_q, value_sh_d;
    logic [3:0]  dp_sh_q, dp_sh_d;
    logic [3:0]  blank_sh_q, blank_sh_d;
    logic [3:0]  blink_sh_q, blink_sh_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        scan_tick;
    logic        blink_s;
    logic        dark;
    logic [3:0]  nibble;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fsync_q    <= '0;
            bsync_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= 2'd3;
            value_sh_q <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
            blink_sh_q <= '0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            fsync_q    <= fsync_d;
            bsync_q    <= bsync_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            value_sh_q <= value_sh_d;
            dp_sh_q    <= dp_sh_d;
            blank_sh_q <= blank_sh_d;
            blink_sh_q <= blink_sh_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        value_sh_d = value_sh_q;
        dp_sh_d    = dp_sh_q;
        blank_sh_d = blank_sh_q;
        blink_sh_d = blink_sh_q;
        fsync_d    = {fsync_q[1:0], bus.clk_fast};
        bsync_d    = {bsync_q[0], bus.clk_1};
        scan_tick  = fsync_q[1] & ~fsync_q[2];
        blink_s    = bsync_q[1];

        // A tick advances the digit from any state, including one mid-guard.
        if (scan_tick) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                value_sh_d = bus.value;
                dp_sh_d    = bus.dp_in;
                blank_sh_d = bus.blank;
                blink_sh_d = bus.blink;
            end
            if (GUARD_CYCLES > 0) begin
                state_d = GUARD;
                cnt_d   = CNT_INIT;
            end else begin
                state_d = DRIVE;
            end
        end else begin
            case (state_q)
                GUARD: begin
                    if (cnt_q == '0) state_d = DRIVE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = state_q;
            endcase
        end

        // Outputs are computed from next-state values so they are registered
        // and already correct on the first DRIVE cycle.
        nibble = value_sh_d[{idx_d, 2'b00} +: 4];
        dark   = blank_sh_d[idx_d] | (blink_sh_d[idx_d] & blink_s);
        if (state_d == DRIVE && !dark) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = decode(nibble);
            dp_d  = ~dp_sh_d[idx_d];
        end else begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.digit_idx = idx_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed literal checks plus randomized scanning
// compared every cycle against a behavioural display model.
module tb_seven_seg_scan;

    localparam int GUARD = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seven_seg_if bus();

    seven_seg_scan #(.GUARD_CYCLES(GUARD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int dec [16] = '{'b1000000, 'b1111001, 'b0100100, 'b0110000,
                     'b0011001, 'b0010010, 'b0000010, 'b1111000,
                     'b0000000, 'b0010000, 'b0001000, 'b0000011,
                     'b1000110, 'b0100001, 'b0000110, 'b0001110};

    // Behavioural model: histories of sampled inputs, digit index, guard time left.
    int m_h1 = 0, m_h2 = 0, m_h3 = 0;
    int m_c1 = 0, m_c2 = 0;
    int m_idx = 3, m_guard = 0, m_drive = 0;
    int m_val = 0, m_dp = 0, m_blank = 0, m_blink = 0;
    int exp_an = 'hF, exp_seg = 'h7F, exp_dp = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h1 = 0; m_h2 = 0; m_h3 = 0; m_c1 = 0; m_c2 = 0;
            m_idx = 3; m_guard = 0; m_drive = 0;
            m_val = 0; m_dp = 0; m_blank = 0; m_blink = 0;
            exp_an = 'hF; exp_seg = 'h7F; exp_dp = 1;
        end else begin
            if (m_h2 == 1 && m_h3 == 0) begin
                m_idx = (m_idx + 1) % 4;
                if (m_idx == 0) begin
                    m_val   = int'(bus.value);
                    m_dp    = int'(bus.dp_in);
                    m_blank = int'(bus.blank);
                    m_blink = int'(bus.blink);
                end
                m_guard = GUARD;
                m_drive = (GUARD == 0) ? 1 : 0;
            end else if (m_guard > 0) begin
                m_guard = m_guard - 1;
                if (m_guard == 0) m_drive = 1;
            end
            if (m_drive == 1 &&
                !(((m_blank >> m_idx) & 1) == 1 || (((m_blink >> m_idx) & 1) == 1 && m_c2 == 1))) begin
                exp_an  = 'hF ^ (1 << m_idx);
                exp_seg = dec[(m_val >> (4 * m_idx)) & 'hF];
                exp_dp  = (((m_dp >> m_idx) & 1) == 1) ? 0 : 1;
            end else begin
                exp_an = 'hF; exp_seg = 'h7F; exp_dp = 1;
            end
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = int'(bus.clk_fast);
            m_c2 = m_c1; m_c1 = int'(bus.clk_1);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_an",  int'(bus.an),        exp_an);
        chk("model_seg", int'(bus.seg),       exp_seg);
        chk("model_dp",  int'(bus.dp),        exp_dp);
        chk("model_idx", int'(bus.digit_idx), m_idx);
    end

    task automatic tick_drive(input int e_idx, input int e_an, input int e_seg);
        @(negedge clk);
        bus.clk_fast = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("tick_idx", int'(bus.digit_idx), e_idx);
        chk("guard_an_first", int'(bus.an), 'hF);
        for (int k = 1; k < GUARD; k++) begin
            @(negedge clk);
            if (k == GUARD - 1) chk("guard_an_last", int'(bus.an), 'hF);
        end
        @(negedge clk);
        chk("drive_an",  int'(bus.an),  e_an);
        chk("drive_seg", int'(bus.seg), e_seg);
        bus.clk_fast = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.clk_fast = 1'b0;
        bus.clk_1    = 1'b0;
        bus.value    = 16'h8A01;
        bus.dp_in    = 4'h0;
        bus.blank    = 4'h0;
        bus.blink    = 4'h0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_an",  int'(bus.an),        'hF);
        chk("reset_seg", int'(bus.seg),       'h7F);
        chk("reset_dp",  int'(bus.dp),        1);
        chk("reset_idx", int'(bus.digit_idx), 3);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // First frame and wrap with value 8A01.
        tick_drive(0, 'b1110, 'b1111001);
        tick_drive(1, 'b1101, 'b1000000);
        tick_drive(2, 'b1011, 'b0001000);
        tick_drive(3, 'b0111, 'b0000000);
        tick_drive(0, 'b1110, 'b1111001);

        // Mid-frame value change stays hidden until the next frame.
        tick_drive(1, 'b1101, 'b1000000);
        bus.value = 16'h5679;
        tick_drive(2, 'b1011, 'b0001000);
        tick_drive(3, 'b0111, 'b0000000);
        tick_drive(0, 'b1110, 'b0010000);

        // Blank digit 2, blink digit 0.
        bus.blank = 4'b0100;
        bus.blink = 4'b0001;
        tick_drive(1, 'b1101, 'b1111000);
        tick_drive(2, 'b1011, 'b0000010);
        tick_drive(3, 'b0111, 'b0010010);
        tick_drive(0, 'b1110, 'b0010000);
        bus.clk_1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("blink_dark_an",  int'(bus.an),  'hF);
        chk("blink_dark_seg", int'(bus.seg), 'h7F);
        bus.clk_1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("blink_lit_an", int'(bus.an), 'b1110);
        tick_drive(1, 'b1101, 'b1111000);
        tick_drive(2, 'hF, 'h7F);
        tick_drive(3, 'b0111, 'b0010010);
        bus.blank = 4'b0000;
        bus.blink = 4'b0000;
        tick_drive(0, 'b1110, 'b0010000);

        // Two ticks five cycles apart: guard restarts, no drive in between.
        @(negedge clk);
        bus.clk_fast = 1'b1;
        repeat (2) @(negedge clk);
        bus.clk_fast = 1'b0;
        repeat (3) @(negedge clk);
        bus.clk_fast = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("double_idx", int'(bus.digit_idx), 2);
        for (int k = 1; k < GUARD; k++) begin
            @(negedge clk);
            chk("double_guard_an", int'(bus.an), 'hF);
        end
        @(negedge clk);
        chk("double_drive_an",  int'(bus.an),  'b1011);
        chk("double_drive_seg", int'(bus.seg), 'b0000010);
        bus.clk_fast = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset while driving.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_an",  int'(bus.an),        'hF);
        chk("async_rst_seg", int'(bus.seg),       'h7F);
        chk("async_rst_dp",  int'(bus.dp),        1);
        chk("async_rst_idx", int'(bus.digit_idx), 3);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tick_drive(0, 'b1110, 'b0010000);

        // Randomized scanning against the model.
        for (int r = 0; r < 60; r++) begin
            @(negedge clk);
            bus.value = 16'($urandom);
            bus.dp_in = 4'($urandom_range(0, 15));
            bus.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus.blink = 4'($urandom_range(0, 15));
            bus.clk_fast = 1'b1;
            repeat ($urandom_range(1, 6)) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) bus.clk_1 = ~bus.clk_1;
            end
            bus.clk_fast = 1'b0;
            repeat ($urandom_range(1, 40)) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) bus.clk_1 = ~bus.clk_1;
            end
        end

        repeat (30) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
